uart_rx_periph: RTL
===================

# uart_rx_periph

UART receiver peripheral for the j1soc, the receive-side counterpart of the SoC's `uart_tx` path. It deserialises an asynchronous 8N1 line into bytes, buffers them in a small FIFO and exposes them to the J1 CPU through the standard chip-select peripheral bus. It sits beside the existing UART transmitter and can be instanced a second time for the Bluetooth link (`bt_rx`).

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate. Bit period `DIV = CLK_HZ/BAUD` (integer truncation); `HALF = DIV/2`.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of two, 2..64.

Ports:
- `sys_clk_i`  in  1: system clock. Everything is on the rising edge.
- `sys_rst_i`  in  1: synchronous, active-low reset.
- `rx_i`  in  1: serial line. Idle-high, asynchronous.
- `cs_i`  in  1: peripheral select.
- `rd_i`  in  1: read strobe, qualified by `cs_i`.
- `wr_i`  in  1: write strobe, qualified by `cs_i`.
- `addr_i`  in  4: register address.
- `d_in`  in  16: write data.
- `d_out`  out  16: registered read data.
- `irq_o`  out  1: high while the FIFO is non-empty or an error flag is set.

## Operation
- `rx_i` passes through a 2-FF synchroniser (reset value 1) before any use.
- Receive FSM states:
  - IDLE → START on the synchronised line going low.
  - START: wait HALF cycles, then re-sample. Low → DATA. High → IDLE (glitch rejected; nothing is logged).
  - DATA: sample every DIV cycles, 8 bits, LSB first, into a shift register.
  - DATA → STOP after the 8th bit.
  - STOP: sample after DIV cycles.
    - High: push the byte.
    - Low: set `FERR` and discard the byte.
  - STOP → IDLE immediately after the stop sample, so back-to-back frames are accepted.
- FIFO push on a full FIFO: byte dropped, `OVR` set, FIFO contents unchanged.
- Register map:
  - 0x0 DATA (read-only): {8'h00, byte}. A read pops the FIFO. Reading while empty returns 0x0000 and leaves pointers unchanged.
  - 0x2 STATUS (read-only), bits:
    - [0] not_empty
    - [1] full
    - [2] FERR
    - [3] OVR
    - [4] PERR
    - [5] busy (FSM ≠ IDLE)
    - [15:8] FIFO count
  - 0x4 CLEAR (write-only): `d_in[2]` clears FERR, `d_in[3]` clears OVR, `d_in[4]` clears PERR, `d_in[0]` flushes the FIFO.
  - Unmapped addresses read as 0x0000; writes to them are ignored.
- Error flags are sticky until cleared.
- If a clear and a new error event land in the same cycle, the set wins.

## Timing
- Reset values:
  - `d_out` = 0, `irq_o` = 0.
  - FSM in IDLE, all flags 0, FIFO empty.
  - Synchroniser = 1.
- Reset asserted mid-frame abandons the frame and leaves no partial byte.
- Line-to-FSM latency: 2 cycles (synchroniser).
- The byte is visible (not_empty = 1) on the cycle after the stop-bit sample.
- Read latency: `cs_i & rd_i` sampled at edge N; `d_out` is valid after edge N and held until the next read.
- The FIFO pop for a DATA read takes effect at edge N. STATUS read at N+1 reflects the pop.
- Simultaneous push and pop: both happen and the count is unchanged. A pop on a full FIFO plus a push in the same cycle does not set OVR.
- Flush plus a simultaneous push: the flush wins and the FIFO ends empty.
- `irq_o` is registered and updates one cycle after the flag or FIFO change.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: an even-parity bit follows bit 7 (adds a PARITY state between DATA and STOP, sampled DIV cycles after bit 7). A mismatch sets `PERR` and the byte is discarded even when the stop bit is good. The frame is 11 bit periods.
  - Undefined: 8N1. The PARITY state is absent and STATUS[4] reads 0.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding.
  - Register addresses 0x0/0x2/0x4.
  - STATUS bit indices.
  - Shared with the transmitter block.
- Sub-module `uart_rx_fifo` (parameterised depth, push/pop/flush, full/empty/count, synchronous active-low reset). The FSM, bit timer and register decode stay in `uart_rx_periph`.

## Test plan
Bench uses `CLK_HZ`=1_000_000 and `BAUD`=100_000 (DIV=10).
1. Frame 0xA5, then read DATA:
   - not_empty rises after the stop sample.
   - DATA read returns 0x00A5.
   - STATUS returns 0x0000 afterwards.
   - `irq_o` rises and then falls.
2. A 3-cycle low glitch on `rx_i`: FSM returns to IDLE, no push, STATUS = 0x0000.
3. Frame 0x3C with the stop bit driven low: FERR = 1 (STATUS = 0x0004), FIFO empty. Write 0x0004 to CLEAR → STATUS = 0x0000.
4. 17 back-to-back frames 0x00..0x10 with no reads:
   - STATUS count = 16, full = 1, OVR = 1.
   - 16 reads return 0x00..0x0F in order.
5. Pop coinciding with the stop sample of a new frame on a FIFO at count 5: count stays 5, no OVR.
6. With `UART_RX_PARITY_EN` defined: frame 0x07 with parity bit 0 → PERR = 1 and no push. The same frame with parity bit 1 → byte 0x07 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, register addresses and
// STATUS bit positions. Also imported by the transmitter block.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h2;
    localparam logic [3:0] ADDR_CLEAR  = 4'h4;

    localparam int ST_BIT_NOT_EMPTY = 0;
    localparam int ST_BIT_FULL      = 1;
    localparam int ST_BIT_FERR      = 2;
    localparam int ST_BIT_OVR       = 3;
    localparam int ST_BIT_PERR      = 4;
    localparam int ST_BIT_BUSY      = 5;

    // Even parity: the parity bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, push/pop/flush, full/empty/count.
// Flush has priority over a simultaneous push or pop. A push on a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];

    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array write port.
    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so it can map to plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_periph.sv
// UART receiver peripheral: 8N1 (or 8E1 with UART_RX_PARITY_EN defined)
// deserialiser, receive FIFO and chip-select register interface.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after bit 7).
module uart_rx_periph #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        rx_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [3:0]  addr_i,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        irq_o
);
    import uart_pkg::*;

    localparam int          DIV       = CLK_HZ / BAUD;
    localparam int          HALF      = DIV / 2;
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    logic [1:0]  sync_q;
    logic        rx_s;
    rx_state_e   state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        half_done, bit_done, stop_sample;
    logic        push, ferr_evt, perr_evt, ovr_evt;
    logic        rd_en, wr_en, pop, flush, clr;
    logic        ferr_q, ovr_q, perr_q, irq_q;
    logic        ferr_d, ovr_d, perr_d;
    logic [15:0] d_out_q, rd_data_d;
    logic [7:0]  fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        unused_d_in;

    assign rx_s      = sync_q[1];
    assign half_done = (timer_q == HALF_LAST);
    assign bit_done  = (timer_q == DIV_LAST);

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) sync_q <= 2'b11;
        else            sync_q <= {sync_q[0], rx_i};
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
`endif

    // Receive FSM with bit timer and LSB-first shift register.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    bit_q   <= '0;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (half_done) begin
                        timer_q <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        timer_q <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_q == 3'd7) state_q <= ST_PARITY;
`else
                        if (bit_q == 3'd7) state_q <= ST_STOP;
`endif
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        timer_q   <= '0;
                        par_bad_q <= (rx_s != even_parity(shift_q));
                        state_q   <= ST_STOP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Frame events are decoded from the registered FSM so the push lands on
    // the stop-sample edge and the byte is visible the following cycle.
    assign stop_sample = (state_q == ST_STOP) && bit_done;
    assign ferr_evt    = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
    assign push     = stop_sample && rx_s && !par_bad_q;
    assign perr_evt = (state_q == ST_PARITY) && bit_done && (rx_s != even_parity(shift_q));
`else
    assign push     = stop_sample && rx_s;
    assign perr_evt = 1'b0;
`endif

    // Bus decode.
    assign rd_en   = cs_i && rd_i;
    assign wr_en   = cs_i && wr_i;
    assign pop     = rd_en && (addr_i == ADDR_DATA);
    assign clr     = wr_en && (addr_i == ADDR_CLEAR);
    assign flush   = clr && d_in[0];
    assign ovr_evt = push && fifo_full && !pop;

    assign unused_d_in = ^{d_in[15:5], d_in[1]};

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rst_i),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky error flags: a new event wins over a clear in the same cycle.
    assign ferr_d = ferr_evt || (ferr_q && !(clr && d_in[2]));
    assign ovr_d  = ovr_evt  || (ovr_q  && !(clr && d_in[3]));
    assign perr_d = perr_evt || (perr_q && !(clr && d_in[4]));

    // Read-data mux for the addressed register.
    // NOTE: the default assignment first guarantees no latch on any path.
    always_comb begin
        rd_data_d = '0;
        case (addr_i)
            ADDR_DATA: begin
                if (!fifo_empty) rd_data_d = {8'h00, fifo_rdata};
            end
            ADDR_STATUS: begin
                rd_data_d[ST_BIT_NOT_EMPTY] = !fifo_empty;
                rd_data_d[ST_BIT_FULL]      = fifo_full;
                rd_data_d[ST_BIT_FERR]      = ferr_q;
                rd_data_d[ST_BIT_OVR]       = ovr_q;
                rd_data_d[ST_BIT_PERR]      = perr_q;
                rd_data_d[ST_BIT_BUSY]      = (state_q != ST_IDLE);
                rd_data_d[15:8]             = 8'(fifo_count);
            end
            default: rd_data_d = '0;
        endcase
    end

    // Registered read data, error flags and interrupt.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            d_out_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (rd_en) d_out_q <= rd_data_d;
            ferr_q <= ferr_d;
            ovr_q  <= ovr_d;
            perr_q <= perr_d;
            irq_q  <= !fifo_empty || ferr_q || ovr_q || perr_q;
        end
    end

    assign d_out = d_out_q;
    assign irq_o = irq_q;

endmodule
